event_irq_unit: RTL and testbench

Collects 32 event/interrupt lines from peripherals, latches rising edges into a pending register, and applies separate interrupt and event masks. It drives the `signal_i` wake input of the sleep controller and the core's interrupt request and ID. It sits directly upstream of the sleep controller on the same APB segment.

---
 rtl/event_unit_pkg.sv | 22 ++
 rtl/event_irq_unit_if.sv | 20 ++
 rtl/event_edge_detect.sv | 47 ++++
 rtl/event_irq_unit.sv | 92 +++++++++
 tb/tb_event_irq_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/event_unit_pkg.sv
// Shared constants for the event/interrupt unit: line count, ID width and
// APB register word indices.
package event_unit_pkg;

  localparam int unsigned NUM_EVENTS = 32;
  localparam int unsigned IRQ_ID_W   = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_IDX_W  = 3;

  localparam logic [REG_IDX_W-1:0] REG_IRQ_MASK    = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_EVT_MASK    = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_PENDING     = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_PENDING_SET = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_PENDING_CLR = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_IRQ_ID      = 3'd5;

  // One-hot decode of an interrupt ID, used for the acknowledge clear.
  function automatic logic [NUM_EVENTS-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    return NUM_EVENTS'(1) << id;
  endfunction

endpackage

// File: rtl/event_irq_unit_if.sv
// APB slave bus bundle for the event/interrupt unit.
interface event_irq_unit_if
  import event_unit_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [DATA_W-1:0]         PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/event_edge_detect.sv
// Per-line input sampling and rising-edge detection.
// EVENT_UNIT_SYNC_EN adds a two-flop synchroniser ahead of the sample stage.
module event_edge_detect
  import event_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] lines,
  output logic [NUM_EVENTS-1:0] edge_c
);

  logic [NUM_EVENTS-1:0] samp_q;
  logic [NUM_EVENTS-1:0] prev_q;

`ifdef EVENT_UNIT_SYNC_EN
  logic [NUM_EVENTS-1:0] sync1_q;
  logic [NUM_EVENTS-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= lines;
      sync2_q <= sync1_q;
      samp_q  <= sync2_q;
      prev_q  <= samp_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      prev_q <= '0;
    end else begin
      samp_q <= lines;
      prev_q <= samp_q;
    end
  end
`endif

  // prev_q resets low, so a line already high at reset release edges once.
  assign edge_c = samp_q & ~prev_q;

endmodule

// File: rtl/event_irq_unit.sv
// Event/interrupt collector: pending latch, IRQ/event masks, APB registers and
// lowest-index priority encoder. Optional synchroniser via EVENT_UNIT_SYNC_EN.
module event_irq_unit
  import event_unit_pkg::*;
(
  input  logic                  HCLK,
  input  logic                  HRESETn,
  event_irq_unit_if.slave       apb,
  input  logic [NUM_EVENTS-1:0] events_i,
  input  logic                  irq_ack_i,
  input  logic [IRQ_ID_W-1:0]   irq_ack_id_i,
  output logic                  irq_o,
  output logic [IRQ_ID_W-1:0]   irq_id_o,
  output logic                  event_o
);

  logic [NUM_EVENTS-1:0] irq_mask_q;
  logic [NUM_EVENTS-1:0] evt_mask_q;
  logic [NUM_EVENTS-1:0] pending_q;
  logic [NUM_EVENTS-1:0] pending_n;
  logic [NUM_EVENTS-1:0] edge_c;
  logic [NUM_EVENTS-1:0] set_c;
  logic [NUM_EVENTS-1:0] clr_c;
  logic [NUM_EVENTS-1:0] irq_active_c;
  logic [REG_IDX_W-1:0]  reg_idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  unused_c;

  event_edge_detect u_edge (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .lines  (events_i),
    .edge_c (edge_c)
  );

  assign reg_idx  = apb.PADDR[4:2];
  assign wr_en    = apb.PSEL && apb.PENABLE && apb.PWRITE;
  assign rd_en    = apb.PSEL && apb.PENABLE && !apb.PWRITE;
  assign unused_c = ^apb.PADDR;

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  // Set has priority over clear so an edge coinciding with an ack is kept.
  always_comb begin
    set_c = edge_c;
    clr_c = '0;
    if (wr_en && (reg_idx == REG_PENDING_SET)) set_c = set_c | apb.PWDATA;
    if (wr_en && (reg_idx == REG_PENDING_CLR)) clr_c = apb.PWDATA;
    if (irq_ack_i) clr_c = clr_c | id_onehot(irq_ack_id_i);
    pending_n = (pending_q & ~clr_c) | set_c;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_mask_q <= '0;
      evt_mask_q <= '0;
      pending_q  <= '0;
    end else begin
      pending_q <= pending_n;
      if (wr_en && (reg_idx == REG_IRQ_MASK)) irq_mask_q <= apb.PWDATA;
      if (wr_en && (reg_idx == REG_EVT_MASK)) evt_mask_q <= apb.PWDATA;
    end
  end

  assign irq_active_c = pending_q & irq_mask_q;
  assign irq_o        = |irq_active_c;
  assign event_o      = |(pending_q & (irq_mask_q | evt_mask_q));

  // Scan downwards so the lowest active index is the last one written.
  always_comb begin
    irq_id_o = '0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (irq_active_c[i]) irq_id_o = IRQ_ID_W'(i);
    end
  end

  always_comb begin
    apb.PRDATA = '0;
    if (rd_en) begin
      case (reg_idx)
        REG_IRQ_MASK: apb.PRDATA = irq_mask_q;
        REG_EVT_MASK: apb.PRDATA = evt_mask_q;
        REG_PENDING:  apb.PRDATA = pending_q;
        REG_IRQ_ID:   apb.PRDATA = {irq_o, (DATA_W - 1 - IRQ_ID_W)'(0), irq_id_o};
        default:      apb.PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_event_irq_unit.sv
// Bench for event_irq_unit: directed scenarios plus randomized traffic against
// a per-line behavioural model of the pending/mask rules.
module tb_event_irq_unit;
  import event_unit_pkg::*;

`ifdef EVENT_UNIT_SYNC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] events_i;
  logic        irq_ack_i;
  logic [4:0]  irq_ack_id_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        event_o;

  always #5 HCLK = ~HCLK;

  event_irq_unit_if #(.APB_ADDR_WIDTH(12)) apb ();

  event_irq_unit dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .apb          (apb),
    .events_i     (events_i),
    .irq_ack_i    (irq_ack_i),
    .irq_ack_id_i (irq_ack_id_i),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o),
    .event_o      (event_o)
  );

  // stimulus for the next cycle
  logic [31:0] t_ev, t_wdata;
  logic [11:0] t_addr;
  logic        t_psel, t_pen, t_pwr, t_ack;
  logic [4:0]  t_ack_id;

  // model state
  bit [31:0] m_imask, m_emask, m_pend, m_prev;
  bit [31:0] m_pipe [DEPTH];

  // observed outputs of the last step
  logic [31:0] obs_prdata;
  logic        obs_irq, obs_evt;
  logic [4:0]  obs_id;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_irq();
    for (int i = 0; i < 32; i++) if (m_pend[i] && m_imask[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] exp_id();
    for (int i = 0; i < 32; i++) if (m_pend[i] && m_imask[i]) return 5'(i);
    return 5'd0;
  endfunction

  function automatic bit exp_evt();
    for (int i = 0; i < 32; i++) if (m_pend[i] && (m_imask[i] || m_emask[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!(t_psel && t_pen && !t_pwr)) return 32'h0;
    case (t_addr[4:2])
      3'd0: return m_imask;
      3'd1: return m_emask;
      3'd2: return m_pend;
      3'd5: return {exp_irq(), 26'h0, exp_id()};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_imask = '0; m_emask = '0; m_pend = '0; m_prev = '0;
    for (int k = 0; k < DEPTH; k++) m_pipe[k] = '0;
  endtask

  // Clock-edge update of the model using the inputs applied this cycle.
  task automatic model_update();
    bit [31:0] samp;
    bit wr;
    samp = m_pipe[DEPTH-1];
    wr = t_psel && t_pen && t_pwr;
    for (int i = 0; i < 32; i++) begin
      bit rose, w1s, w1c, ackd;
      rose = samp[i] && !m_prev[i];
      w1s  = wr && (t_addr[4:2] == 3'd3) && t_wdata[i];
      w1c  = wr && (t_addr[4:2] == 3'd4) && t_wdata[i];
      ackd = t_ack && (int'(t_ack_id) == i);
      if (rose || w1s) m_pend[i] = 1'b1;
      else if (w1c || ackd) m_pend[i] = 1'b0;
    end
    if (wr && t_addr[4:2] == 3'd0) m_imask = t_wdata;
    if (wr && t_addr[4:2] == 3'd1) m_emask = t_wdata;
    m_prev = samp;
    for (int k = DEPTH - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = t_ev;
  endtask

  task automatic step();
    @(negedge HCLK);
    apb.PADDR = t_addr; apb.PWDATA = t_wdata; apb.PWRITE = t_pwr;
    apb.PSEL = t_psel; apb.PENABLE = t_pen;
    events_i = t_ev; irq_ack_i = t_ack; irq_ack_id_i = t_ack_id;
    #1;
    obs_prdata = apb.PRDATA; obs_irq = irq_o; obs_id = irq_id_o; obs_evt = event_o;
    chk("irq_o", 32'(irq_o), 32'(exp_irq()));
    chk("irq_id_o", 32'(irq_id_o), 32'(exp_id()));
    chk("event_o", 32'(event_o), 32'(exp_evt()));
    chk("PRDATA", apb.PRDATA, exp_rd());
    chk("PREADY", 32'(apb.PREADY), 32'h1);
    chk("PSLVERR", 32'(apb.PSLVERR), 32'h0);
    @(posedge HCLK);
    model_update();
  endtask

  task automatic bus_idle();
    t_psel = 0; t_pen = 0; t_pwr = 0; t_addr = '0; t_wdata = '0; t_ack = 0; t_ack_id = '0;
  endtask

  task automatic idle(input int n);
    bus_idle();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic apb_wr(input int idx, input logic [31:0] data);
    bus_idle();
    t_psel = 1; t_pen = 1; t_pwr = 1; t_addr = 12'(idx << 2); t_wdata = data;
    step();
    bus_idle();
  endtask

  task automatic apb_rd(input int idx);
    bus_idle();
    t_psel = 1; t_pen = 1; t_pwr = 0; t_addr = 12'(idx << 2);
    step();
    bus_idle();
  endtask

  task automatic pulse(input logic [31:0] ev);
    t_ev = ev; idle(1); t_ev = '0;
  endtask

  initial begin
    bus_idle(); t_ev = '0;
    model_reset();
    HRESETn = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0; apb.PWRITE = 0; apb.PSEL = 0; apb.PENABLE = 0;
    events_i = '0; irq_ack_i = 0; irq_ack_id_i = '0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("reset irq_o", 32'(irq_o), 32'h0);
    chk("reset event_o", 32'(event_o), 32'h0);
    chk("reset irq_id_o", 32'(irq_id_o), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // all registers read zero after reset
    for (int r = 0; r < 8; r++) begin
      apb_rd(r);
      chk($sformatf("reset read reg%0d", r), obs_prdata, 32'h0);
    end

    // IRQ on line 4, then ack
    apb_wr(0, 32'h0000_0010);
    pulse(32'h10);
    idle(4);
    apb_rd(2);
    chk("line4 PENDING", obs_prdata, 32'h10);
    chk("line4 irq_o", 32'(obs_irq), 32'h1);
    chk("line4 irq_id", 32'(obs_id), 32'h4);
    chk("line4 event_o", 32'(obs_evt), 32'h1);
    t_ack = 1; t_ack_id = 5'd4; step(); bus_idle();
    idle(1);
    chk("ack4 irq_o", 32'(obs_irq), 32'h0);

    // event-only line 0, cleared through PENDING_CLR
    apb_wr(0, 32'h0);
    apb_wr(1, 32'h1);
    pulse(32'h1);
    idle(4);
    chk("evt0 event_o", 32'(obs_evt), 32'h1);
    chk("evt0 irq_o", 32'(obs_irq), 32'h0);
    apb_wr(4, 32'h1);
    idle(1);
    chk("evt0 clr event_o", 32'(obs_evt), 32'h0);

    // priority between lines 7 and 3
    apb_wr(0, 32'hFFFF_FFFF);
    pulse(32'h88);
    idle(4);
    chk("prio id3", 32'(obs_id), 32'h3);
    t_ack = 1; t_ack_id = 5'd3; step(); bus_idle();
    idle(1);
    chk("prio id7", 32'(obs_id), 32'h7);
    t_ack = 1; t_ack_id = 5'd7; step(); bus_idle();
    idle(1);
    chk("prio idle irq_o", 32'(obs_irq), 32'h0);

    // ack of line 5 racing a new rising edge on line 5
    pulse(32'h20);
    idle(4);
    t_ev = 32'h20;
    idle(DEPTH);
    t_ack = 1; t_ack_id = 5'd5; step(); bus_idle();
    t_ev = '0;
    idle(1);
    apb_rd(2);
    chk("ack race PENDING[5]", 32'(obs_prdata[5]), 32'h1);

    // held level edges only once; W1S re-sets without an edge
    apb_wr(4, 32'hFFFF_FFFF);
    t_ev = 32'h200;
    idle(5);
    apb_wr(4, 32'h200);
    idle(5);
    apb_rd(2);
    chk("held line9 PENDING", obs_prdata, 32'h0);
    t_ev = '0;
    apb_wr(3, 32'h200);
    idle(1);
    apb_rd(2);
    chk("w1s line9 PENDING", obs_prdata, 32'h200);

    // randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        model_reset();
        chk("midreset irq_o", 32'(irq_o), 32'h0);
        chk("midreset event_o", 32'(event_o), 32'h0);
        chk("midreset irq_id_o", 32'(irq_id_o), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
      end
      t_ev   = $urandom & $urandom & $urandom;
      t_psel = ($urandom_range(0, 3) != 0);
      t_pen  = ($urandom_range(0, 1) != 0);
      t_pwr  = ($urandom_range(0, 1) != 0);
      t_addr = 12'($urandom);
      t_wdata = (t_addr[4:2] == 3'd3) ? ($urandom & $urandom & $urandom) : $urandom;
      t_ack  = ($urandom_range(0, 3) == 0);
      t_ack_id = ($urandom_range(0, 1) != 0) ? exp_id() : 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
